key_expansion: RTL
==================

// Module: key_expansion
// PURPOSE
//   Iterative AES-128 key schedule. Expands a 128-bit cipher key into 11 round keys
//   (1408 bits), one 32-bit word per cycle, with a start/finish handshake.
//   Sits directly upstream of the round-key addition stage; its key_out drives that
//   stage's expanded-key input, which selects round key r at bits [128*r +: 128].
//   Contains its own SubWord S-box (4 parallel byte lookups, combinational).
// PARAMETERS
//   None. Fixed AES-128: Nk=4, Nr=10, 44 words, 1408-bit output.
// PORTS
//   clk      input   1     clock, all state updates on posedge
//   rst      input   1     reset, synchronous, active-high
//   start    input   1     request expansion of key; honoured only when busy=0
//   key      input   128   cipher key, byte 0 at [127:120]; sampled only on acceptance
//   key_out  output  1408  expanded key; round key r = key_out[128*r +: 128]
//   busy     output  1     high while expansion in progress
//   finish   output  1     high (level) once all 11 round keys are valid
// BEHAVIOUR
//   - Reset (rst=1 at posedge): key_out=0, busy=0, finish=0, FSM=IDLE, word index=0,
//     rcon=8'h01. Reset overrides everything, including mid-expansion; no partial result kept.
//   - Word layout: round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]},
//     w[4r] at [128r+127 : 128r+96]. Round 0 = key unchanged.
//   - FSM: IDLE -> EXPAND on start; EXPAND -> IDLE after word 43 is written.
//   - Acceptance edge (IDLE, start=1, call it edge T): key_out[127:0]<=key,
//     key_out[1407:128]<=0, index i<=4, rcon<=8'h01, busy<=1, finish<=0.
//   - Each EXPAND edge computes w[i] and writes it into key_out, then i<=i+1:
//       temp = w[i-1];
//       if (i%4==0) temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon<=xtime(rcon);
//       w[i] = w[i-4] ^ temp.
//     RotWord({a,b,c,d}) = {b,c,d,a}. SubWord = FIPS-197 S-box per byte.
//     xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
//     rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
//   - w[i-1] and w[i-4] are read back from key_out (or equivalent internal copy),
//     never from the key port.
//   - Word 4 is written at edge T+1; word 43 at edge T+40. At edge T+40: busy<=0,
//     finish<=1, FSM<=IDLE. Latency from acceptance edge to finish=1: 40 cycles.
//   - Partial output: while busy=1, words not yet computed read as 0.
//     Consumers only use key_out while finish=1.
//   - Ownership: key is not sampled after acceptance. start while busy=1 is ignored,
//     with no effect on the result or on timing.
//   - finish stays high with key_out stable until the next accepted start or reset.
//     start in IDLE with finish=1 restarts: finish<=0 at that edge.
//   - start held high continuously restarts the expansion on the edge after each
//     completion (back-to-back; one IDLE cycle between runs).
// TESTING
//   1) FIPS-197 A.1: key=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle.
//      Expected: finish rises 40 cycles after acceptance;
//      key_out[255:128]=a0fafe1788542cb123a339392a6c7605;
//      key_out[1407:1280]=d014f9a8c9ee2589e13f0cc8b6630ca6; key_out[127:0]=key.
//   2) Zero key: key=0.
//      Expected: round 1 = 62636363626363636263636362636363;
//      round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; busy=1 for exactly 40 cycles.
//   3) Ignored start and key change: during test 1, pulse start and change key to all-ones
//      at cycle 10. Expected: results identical to test 1, finish still at cycle 40.
//   4) Reset mid-run: assert rst at cycle 20 of an expansion.
//      Expected: next cycle key_out=0, busy=0, finish=0.
//      A new start with the A.1 key then gives test-1 results.
//   5) Restart after done: run A.1, then start with key=0 while finish=1.
//      Expected: finish drops on the acceptance edge, key_out[1407:128]=0, key_out[127:0]=0;
//      after 40 cycles the zero-key results appear.
//   6) Idle hold: no start for 100 cycles after test 1.
//      Expected: finish stays 1 and key_out is unchanged bit-for-bit.

Source files
------------

// File: rtl/key_expansion_if.sv
// ---------------------------------------------------------------------------
// key_expansion_if
//   Groups the key-schedule handshake and data signals.
//   start    : request expansion of key (requester -> expander)
//   key      : 128-bit cipher key, byte 0 at [127:120] (requester -> expander)
//   key_out  : 1408-bit expanded key, round r at [128*r +: 128] (expander -> requester)
//   busy     : expansion in progress (expander -> requester)
//   finish   : level, all 11 round keys valid (expander -> requester)
//   master modport = requester side, slave modport = key_expansion itself.
// ---------------------------------------------------------------------------
interface key_expansion_if;
  logic          start;
  logic [127:0]  key;
  logic [1407:0] key_out;
  logic          busy;
  logic          finish;

  modport master (output start, key, input key_out, busy, finish);
  modport slave  (input start, key, output key_out, busy, finish);
endinterface

// File: rtl/key_expansion.sv
// ---------------------------------------------------------------------------
// key_expansion
//   Iterative AES-128 key schedule: one 32-bit word of the 44-word schedule is
//   produced per clock after the key is accepted, so finish rises 40 cycles
//   after the acceptance edge. Words not yet computed read as zero.
//   Ports:
//     clk  : clock, all state on posedge
//     rst  : synchronous active-high reset
//     bus  : key_expansion_if.slave (start, key, key_out, busy, finish)
// ---------------------------------------------------------------------------
module key_expansion (
  input  logic           clk,
  input  logic           rst,
  key_expansion_if.slave bus
);

  typedef enum logic {IDLE, EXPAND} state_t;

  // FIPS-197 S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t          state_reg, state_next;
  logic [1407:0]   key_out_reg, key_out_next;
  logic [5:0]      idx_reg, idx_next;
  logic [7:0]      rcon_reg, rcon_next;
  logic            busy_reg, busy_next;
  logic            finish_reg, finish_next;

  // Word-indexed view of the schedule: word 4r+j sits in round r, column j,
  // with column 0 in the top 32 bits of the round key.
  logic [31:0] w [44];
  for (genvar gi = 0; gi < 44; gi++) begin : g_word_view
    assign w[gi] = key_out_reg[128*(gi/4) + 96 - 32*(gi%4) +: 32];
  end

  logic [31:0] prev_word, back_word, rot_word, sub_word, temp_word, new_word;
  logic [10:0] word_base;
  logic [7:0]  rcon_xtime;

  // Only meaningful in EXPAND, where idx_reg is 4..43.
  assign prev_word = w[idx_reg - 6'd1];
  assign back_word = w[idx_reg - 6'd4];
  assign rot_word  = {prev_word[23:0], prev_word[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub_word
    assign sub_word[8*gi +: 8] = SBOX[rot_word[8*gi +: 8]];
  end

  assign temp_word  = (idx_reg[1:0] == 2'd0) ? (sub_word ^ {rcon_reg, 24'h0}) : prev_word;
  assign new_word   = back_word ^ temp_word;
  assign word_base  = {idx_reg[5:2], 7'd0} + 11'd96 - {4'd0, idx_reg[1:0], 5'd0};
  assign rcon_xtime = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_next   = state_reg;
    key_out_next = key_out_reg;
    idx_next     = idx_reg;
    rcon_next    = rcon_reg;
    busy_next    = busy_reg;
    finish_next  = finish_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          // Clearing rounds 1..10 keeps not-yet-computed words at zero.
          key_out_next = {1280'd0, bus.key};
          idx_next     = 6'd4;
          rcon_next    = 8'h01;
          busy_next    = 1'b1;
          finish_next  = 1'b0;
          state_next   = EXPAND;
        end
      end
      EXPAND: begin
        key_out_next[word_base +: 32] = new_word;
        idx_next = idx_reg + 6'd1;
        if (idx_reg[1:0] == 2'd0) begin
          rcon_next = rcon_xtime;
        end
        if (idx_reg == 6'd43) begin
          busy_next   = 1'b0;
          finish_next = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      key_out_reg <= '0;
      idx_reg     <= '0;
      rcon_reg    <= 8'h01;
      busy_reg    <= 1'b0;
      finish_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      key_out_reg <= key_out_next;
      idx_reg     <= idx_next;
      rcon_reg    <= rcon_next;
      busy_reg    <= busy_next;
      finish_reg  <= finish_next;
    end
  end

  assign bus.key_out = key_out_reg;
  assign bus.busy    = busy_reg;
  assign bus.finish  = finish_reg;

endmodule
